// File: rtl/gcd_engine_param.sv
// gcd_engine_param: WIDTH-bit GCD engine, subtractive Euclid (MODE=0) or binary Stein (MODE=1),
// with a start/ready handshake, saturating cycle counter and zero-operand error flag.
module gcd_engine_param #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] cycles,
    output logic             err
);
    localparam int KW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a, b, res;
    logic [KW-1:0] k;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic fin;
    assign ready  = state == IDLE;
    assign busy   = state == CALC;
    assign cnt_nx = &cnt ? cnt : cnt + 1'b1;
    assign fin    = a == '0 || b == '0 || a == b;
    // when a==b the OR equals a, so one expression covers both terminating cases
    assign res    = (a | b) << k;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            k       <= '0;
            cnt     <= '0;
            gcd_out <= '0;
            cycles  <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a     <= a_in;
                    b     <= b_in;
                    k     <= '0;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    cnt <= cnt_nx;
                    if (fin) begin
                        gcd_out <= res;
                        cycles  <= cnt_nx;
                        err     <= a == '0 && b == '0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (MODE == 0 || (a[0] && b[0])) begin
                        if (a > b) a <= a - b;
                        else b <= b - a;
                    end else begin
                        if (!a[0]) a <= a >> 1;
                        if (!b[0]) b <= b >> 1;
                        if (!a[0] && !b[0]) k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_engine_param.sv
// tb_gcd_engine_param: directed checks of the GCD engine in both modes plus a narrow saturating instance.
module tb_gcd_engine_param;
    logic clk = 0, rst = 1;
    logic [2:0] st = '0;
    logic [15:0] a_in = '0, b_in = '0;
    logic [2:0] rdy, bsy, dn, er;
    logic [15:0] g0, g1, cy0, cy1;
    logic [7:0] g2;
    logic [3:0] cy2;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    gcd_engine_param #(.WIDTH(16), .MODE(0), .CNT_W(16)) d0 (
        .clk(clk), .rst(rst), .start(st[0]), .a_in(a_in), .b_in(b_in), .ready(rdy[0]),
        .busy(bsy[0]), .done(dn[0]), .gcd_out(g0), .cycles(cy0), .err(er[0]));
    gcd_engine_param #(.WIDTH(16), .MODE(1), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .start(st[1]), .a_in(a_in), .b_in(b_in), .ready(rdy[1]),
        .busy(bsy[1]), .done(dn[1]), .gcd_out(g1), .cycles(cy1), .err(er[1]));
    gcd_engine_param #(.WIDTH(8), .MODE(0), .CNT_W(4)) d2 (
        .clk(clk), .rst(rst), .start(st[2]), .a_in(a_in[7:0]), .b_in(b_in[7:0]), .ready(rdy[2]),
        .busy(bsy[2]), .done(dn[2]), .gcd_out(g2), .cycles(cy2), .err(er[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int cref(input int a, input int b);
        int n = 1;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) a -= b;
            else b -= a;
            n++;
        end
        return n;
    endfunction

    task automatic op(input int u, input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        a_in = a;
        b_in = b;
        st[u] = 1'b1;
        @(negedge clk);
        st[u] = 1'b0;
        lat = 0;
        while (!dn[u] && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'd0, dn[u]}, 1);
        @(negedge clk);
        check("done_pulse", {31'd0, dn[u]}, 0);
        check("ready_after", {31'd0, rdy[u]}, 1);
    endtask

    initial begin
        int lat, ra, rb;
        bit seen;
        #2;
        check("rst_gcd", {16'd0, g0}, 0);
        check("rst_cycles", {16'd0, cy0}, 0);
        check("rst_err", {31'd0, er[0]}, 0);
        check("rst_done", {29'd0, dn}, 0);
        check("rst_ready", {29'd0, rdy}, 7);
        check("rst_busy", {29'd0, bsy}, 0);
        @(negedge clk);
        rst = 0;

        op(0, 48, 18, lat);
        check("t1_lat", lat, 5);
        check("t1_gcd", {16'd0, g0}, 6);
        check("t1_cycles", {16'd0, cy0}, 5);
        check("t1_err", {31'd0, er[0]}, 0);

        op(1, 48, 18, lat);
        check("t2_lat", lat, 7);
        check("t2_gcd", {16'd0, g1}, 6);
        check("t2_cycles", {16'd0, cy1}, 7);

        for (int u = 0; u < 2; u++) begin
            op(u, 0, 7, lat);
            check("t3_gcd07", {16'd0, u ? g1 : g0}, 7);
            check("t3_cyc07", {16'd0, u ? cy1 : cy0}, 1);
            check("t3_err07", {31'd0, er[u]}, 0);
            op(u, 0, 0, lat);
            check("t3_gcd00", {16'd0, u ? g1 : g0}, 0);
            check("t3_cyc00", {16'd0, u ? cy1 : cy0}, 1);
            check("t3_err00", {31'd0, er[u]}, 1);
            op(u, 21, 21, lat);
            check("t4_eq_gcd", {16'd0, u ? g1 : g0}, 21);
            check("t4_eq_cyc", {16'd0, u ? cy1 : cy0}, 1);
            check("t4_eq_err", {31'd0, er[u]}, 0);
        end
        op(0, 17, 5, lat);
        check("t4_cop_gcd", {16'd0, g0}, 1);
        check("t4_cop_cyc", {16'd0, cy0}, 7);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            op(0, ra[15:0], rb[15:0], lat);
            check("rnd0_gcd", {16'd0, g0}, gref(ra, rb));
            check("rnd0_cyc", {16'd0, cy0}, cref(ra, rb));
            check("rnd0_err", {31'd0, er[0]}, (ra == 0 && rb == 0) ? 1 : 0);
            op(1, ra[15:0], rb[15:0], lat);
            check("rnd1_gcd", {16'd0, g1}, gref(ra, rb));
        end

        @(negedge clk);
        a_in = 48;
        b_in = 18;
        st[0] = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!dn[0] && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("t5_lat1", lat, 5);
        check("t5_gcd1", {16'd0, g0}, 6);
        a_in = 21;
        b_in = 14;
        @(negedge clk);
        check("t5_pulse", {31'd0, dn[0]}, 0);
        check("t5_ready", {31'd0, rdy[0]}, 1);
        @(negedge clk);
        check("t5_busy", {31'd0, bsy[0]}, 1);
        lat = 0;
        while (!dn[0] && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("t5_lat2", lat, 3);
        check("t5_gcd2", {16'd0, g0}, 7);
        st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_idle", {31'd0, rdy[0]}, 1);

        @(negedge clk);
        a_in = 16'hFFFF;
        b_in = 1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_busy", {31'd0, bsy[0]}, 1);
        #1 rst = 1;
        #1;
        check("t6_gcd", {16'd0, g0}, 0);
        check("t6_cyc", {16'd0, cy0}, 0);
        check("t6_err", {31'd0, er[0]}, 0);
        check("t6_ready", {31'd0, rdy[0]}, 1);
        check("t6_busy0", {31'd0, bsy[0]}, 0);
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen |= dn[0];
        end
        check("t6_nodone", {31'd0, seen}, 0);
        op(2, 255, 1, lat);
        check("t6_lat", lat, 255);
        check("t6_gcd8", {24'd0, g2}, 1);
        check("t6_sat", {28'd0, cy2}, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
